// File: rtl/sdp_bs_op_feed.sv
// sdp_bs_op_feed: BS operand feeder, DMA beats to per-lane ALU/MUL operand streams; SDP_OP_FEED_PERF_EN adds perf_stall_cnt.
module sdp_bs_op_feed #(
    parameter int THROUGHPUT = 1,
    parameter int OP_DW = 16
) (
    input  logic                             nvdla_core_clk,
    input  logic                             nvdla_core_rst,
    input  logic                             op_en,
    input  logic                             cfg_mode,
    input  logic [12:0]                      cfg_width,
    input  logic [12:0]                      cfg_height,
    input  logic [12:0]                      cfg_channel,
    input  logic                             cfg_alu_en,
    input  logic                             cfg_mul_en,
    input  logic                             dma_rd_pvld,
    output logic                             dma_rd_prdy,
    input  logic [2*OP_DW*THROUGHPUT-1:0]    dma_rd_pd,
    output logic                             chn_alu_op_pvld,
    input  logic                             chn_alu_op_prdy,
    output logic [OP_DW*THROUGHPUT-1:0]      chn_alu_op,
    output logic                             chn_mul_op_pvld,
    input  logic                             chn_mul_op_prdy,
    output logic [OP_DW*THROUGHPUT-1:0]      chn_mul_op,
    output logic                             op_busy,
    output logic                             op_done
`ifdef SDP_OP_FEED_PERF_EN
    ,
    output logic [31:0]                      perf_stall_cnt
`endif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam int DW = OP_DW * THROUGHPUT;

    logic [1:0]    state;
    logic          mode_r, alu_en_r, mul_en_r, sent_alu, sent_mul;
    logic [12:0]   width_r, height_r, channel_r, w_cnt, h_cnt, c_cnt;
    logic [DW-1:0] alu_op, mul_op, alu_in, mul_in;
    logic          alu_fin, mul_fin, beat_done, w_last, h_last, c_last, wh_wrap;

    always_comb begin
        alu_in = '0;
        mul_in = '0;
        for (int i = 0; i < THROUGHPUT; i++) begin
            alu_in[OP_DW*i +: OP_DW] = dma_rd_pd[2*OP_DW*i +: OP_DW];
            mul_in[OP_DW*i +: OP_DW] = dma_rd_pd[2*OP_DW*i+OP_DW +: OP_DW];
        end
    end

    assign dma_rd_prdy     = state == LOAD;
    assign chn_alu_op_pvld = state == SEND && !sent_alu;
    assign chn_mul_op_pvld = state == SEND && !sent_mul;
    assign chn_alu_op      = alu_op;
    assign chn_mul_op      = mul_op;
    assign op_busy         = state != IDLE;
    // a handshake in the current cycle counts towards completing the beat
    assign alu_fin   = sent_alu | (chn_alu_op_pvld & chn_alu_op_prdy);
    assign mul_fin   = sent_mul | (chn_mul_op_pvld & chn_mul_op_prdy);
    assign beat_done = state == SEND && alu_fin && mul_fin;
    assign w_last    = w_cnt == width_r;
    assign h_last    = h_cnt == height_r;
    assign c_last    = c_cnt == channel_r;
    assign wh_wrap   = w_last && h_last;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state     <= IDLE;
            mode_r    <= 1'b0;
            alu_en_r  <= 1'b0;
            mul_en_r  <= 1'b0;
            width_r   <= '0;
            height_r  <= '0;
            channel_r <= '0;
            w_cnt     <= '0;
            h_cnt     <= '0;
            c_cnt     <= '0;
            alu_op    <= '0;
            mul_op    <= '0;
            sent_alu  <= 1'b0;
            sent_mul  <= 1'b0;
            op_done   <= 1'b0;
        end else begin
            op_done <= 1'b0;
            case (state)
                IDLE: if (op_en) begin
                    mode_r    <= cfg_mode;
                    alu_en_r  <= cfg_alu_en;
                    mul_en_r  <= cfg_mul_en;
                    width_r   <= cfg_width;
                    height_r  <= cfg_height;
                    channel_r <= cfg_channel;
                    w_cnt     <= '0;
                    h_cnt     <= '0;
                    c_cnt     <= '0;
                    alu_op    <= '0;
                    mul_op    <= '0;
                    state     <= (cfg_alu_en | cfg_mul_en) ? LOAD : IDLE;
                    op_done   <= !(cfg_alu_en | cfg_mul_en);
                end
                LOAD: if (dma_rd_pvld) begin
                    alu_op   <= alu_en_r ? alu_in : '0;
                    mul_op   <= mul_en_r ? mul_in : '0;
                    sent_alu <= !alu_en_r;
                    sent_mul <= !mul_en_r;
                    state    <= SEND;
                end
                SEND: if (beat_done) begin
                    w_cnt    <= w_last ? '0 : w_cnt + 13'd1;
                    h_cnt    <= w_last ? (h_last ? '0 : h_cnt + 13'd1) : h_cnt;
                    c_cnt    <= wh_wrap ? (c_last ? '0 : c_cnt + 13'd1) : c_cnt;
                    sent_alu <= !alu_en_r;
                    sent_mul <= !mul_en_r;
                    state    <= (wh_wrap && c_last) ? IDLE : (!mode_r || wh_wrap) ? LOAD : SEND;
                    op_done  <= wh_wrap && c_last;
                end else begin
                    sent_alu <= alu_fin;
                    sent_mul <= mul_fin;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SDP_OP_FEED_PERF_EN
    logic stall;
    assign stall = (chn_alu_op_pvld & !chn_alu_op_prdy) | (chn_mul_op_pvld & !chn_mul_op_prdy);

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst)
            perf_stall_cnt <= '0;
        else if (state == IDLE && op_en)
            perf_stall_cnt <= '0;
        else if (stall && perf_stall_cnt != 32'hFFFF_FFFF)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_sdp_bs_op_feed.sv
// tb_sdp_bs_op_feed: randomized and directed checks of sdp_bs_op_feed against a queue-based operand model.
module tb_sdp_bs_op_feed;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_en = 1'b0, cfg_mode = 1'b0, cfg_alu_en = 1'b0, cfg_mul_en = 1'b0;
    logic [12:0] cfg_width = '0, cfg_height = '0, cfg_channel = '0;
    logic        dma_rd_pvld = 1'b0, dma_rd_prdy;
    logic [31:0] dma_rd_pd = '0;
    logic        chn_alu_op_pvld, chn_alu_op_prdy = 1'b0, chn_mul_op_pvld, chn_mul_op_prdy = 1'b0;
    logic [15:0] chn_alu_op, chn_mul_op;
    logic        op_busy, op_done;
`ifdef SDP_OP_FEED_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    sdp_bs_op_feed #(.THROUGHPUT(1), .OP_DW(16)) dut (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .op_en(op_en), .cfg_mode(cfg_mode),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_channel(cfg_channel),
        .cfg_alu_en(cfg_alu_en), .cfg_mul_en(cfg_mul_en),
        .dma_rd_pvld(dma_rd_pvld), .dma_rd_prdy(dma_rd_prdy), .dma_rd_pd(dma_rd_pd),
        .chn_alu_op_pvld(chn_alu_op_pvld), .chn_alu_op_prdy(chn_alu_op_prdy), .chn_alu_op(chn_alu_op),
        .chn_mul_op_pvld(chn_mul_op_pvld), .chn_mul_op_prdy(chn_mul_op_prdy), .chn_mul_op(chn_mul_op),
        .op_busy(op_busy), .op_done(op_done)
`ifdef SDP_OP_FEED_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0, errs = 0;
    int cyc = 0, last_ev = 0, done_seen = 0, dma_cnt = 0, dma_exp = 0, stall_m = 0;
    int alu_pct = 100, mul_pct = 100, pvld_pct = 100, alu_hold = 0, mul_hold = 0;
    bit en_alu, en_mul, in_layer, started, pa_v, pa_r, pm_v, pm_r;
    logic [15:0] pa_d, pm_d;
    logic [15:0] alu_q[$], mul_q[$];
    logic [31:0] beat_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clock: check what the DUT shows now, then drive the inputs for the coming edge
    task automatic step(input bit go);
        bit ah, mh;
        @(negedge clk);
        cyc++;
        if (!en_alu && (in_layer || op_done)) chk("alu_off", {chn_alu_op_pvld, chn_alu_op}, 0);
        if (!en_mul && (in_layer || op_done)) chk("mul_off", {chn_mul_op_pvld, chn_mul_op}, 0);
        if (op_done) begin
            done_seen++;
            chk("done_lat", cyc, last_ev + 1);
            chk("busy_at_done", op_busy, 0);
            in_layer = 0;
        end else if (in_layer) chk("busy", op_busy, 1);
`ifdef SDP_OP_FEED_PERF_EN
        if (started) chk("perf_clr", perf_stall_cnt, 0);
`endif
        started = 0;
        if (pa_v && !pa_r) chk("alu_hold", {chn_alu_op_pvld, chn_alu_op}, {1'b1, pa_d});
        if (pm_v && !pm_r) chk("mul_hold", {chn_mul_op_pvld, chn_mul_op}, {1'b1, pm_d});
        if (dma_rd_prdy) chk("prdy_excl", {op_busy, chn_alu_op_pvld, chn_mul_op_pvld}, 3'b100);
        op_en = go;
        if (go) begin
            last_ev = cyc; stall_m = 0; in_layer = en_alu | en_mul; started = 1;
        end
        chn_alu_op_prdy = (alu_hold > 0) ? 1'b0 : ($urandom_range(99) < alu_pct);
        chn_mul_op_prdy = (mul_hold > 0) ? 1'b0 : ($urandom_range(99) < mul_pct);
        if (alu_hold > 0 && chn_alu_op_pvld) alu_hold--;
        if (mul_hold > 0 && chn_mul_op_pvld) mul_hold--;
        ah = chn_alu_op_pvld && chn_alu_op_prdy;
        mh = chn_mul_op_pvld && chn_mul_op_prdy;
        if (ah) begin
            chk("alu_expected", alu_q.size() > 0, 1);
            if (alu_q.size() > 0) chk("alu_data", chn_alu_op, alu_q.pop_front());
            last_ev = cyc;
        end
        if (mh) begin
            chk("mul_expected", mul_q.size() > 0, 1);
            if (mul_q.size() > 0) chk("mul_data", chn_mul_op, mul_q.pop_front());
            last_ev = cyc;
        end
        if ((chn_alu_op_pvld && !chn_alu_op_prdy) || (chn_mul_op_pvld && !chn_mul_op_prdy)) stall_m++;
        dma_rd_pvld = beat_q.size() > 0 && $urandom_range(99) < pvld_pct;
        dma_rd_pd = beat_q.size() > 0 ? beat_q[0] : $urandom;
        if (dma_rd_pvld && dma_rd_prdy) begin
            void'(beat_q.pop_front());
            dma_cnt++;
        end
        pa_v = chn_alu_op_pvld; pa_r = chn_alu_op_prdy; pa_d = chn_alu_op;
        pm_v = chn_mul_op_pvld; pm_r = chn_mul_op_prdy; pm_d = chn_mul_op;
    endtask

    // expected streams straight from the layer shape: each beat repeats W*H times in per-channel mode
    task automatic gen_layer(input bit mode, input int w, input int h, input int c, input bit ea, input bit em);
        int nb, reps;
        logic [31:0] b;
        alu_q.delete(); mul_q.delete(); beat_q.delete();
        nb = !(ea | em) ? 0 : mode ? c + 1 : (w + 1) * (h + 1) * (c + 1);
        reps = mode ? (w + 1) * (h + 1) : 1;
        for (int k = 0; k < nb; k++) begin
            b = $urandom;
            beat_q.push_back(b);
            for (int r = 0; r < reps; r++) begin
                if (ea) alu_q.push_back(b[15:0]);
                if (em) mul_q.push_back(b[31:16]);
            end
        end
        dma_exp = nb;
    endtask

    task automatic run_layer(input bit mode, input int w, input int h, input int c, input bit ea, input bit em);
        int n = 0;
        cfg_mode = mode; cfg_width = 13'(w); cfg_height = 13'(h); cfg_channel = 13'(c);
        cfg_alu_en = ea; cfg_mul_en = em; en_alu = ea; en_mul = em;
        done_seen = 0; dma_cnt = 0;
        step(1);
        while (done_seen == 0 && n < 3000) begin
            step(0);
            n++;
        end
        chk("done_in_budget", done_seen > 0, 1);
        repeat (2) step(0);
        chk("done_count", done_seen, 1);
        chk("dma_count", dma_cnt, dma_exp);
        chk("alu_left", alu_q.size(), 0);
        chk("mul_left", mul_q.size(), 0);
`ifdef SDP_OP_FEED_PERF_EN
        chk("perf_cnt", perf_stall_cnt, stall_m);
`endif
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {dma_rd_prdy, chn_alu_op_pvld, chn_mul_op_pvld, op_busy, op_done, chn_alu_op, chn_mul_op}, 0);
        rst = 1'b0;
        repeat (2) step(0);

        // two per-element beats, literal operands
        alu_q = '{16'h0001, 16'h0003}; mul_q = '{16'h0002, 16'h0004};
        beat_q = '{32'h0002_0001, 32'h0004_0003}; dma_exp = 2;
        run_layer(0, 1, 0, 0, 1, 1);

        // per-channel 3x2x2: each channel beat is replayed six times
        alu_q.delete(); mul_q.delete();
        for (int k = 0; k < 6; k++) begin alu_q.push_back(16'h00AA); mul_q.push_back(16'h00BB); end
        for (int k = 0; k < 6; k++) begin alu_q.push_back(16'h00CC); mul_q.push_back(16'h00DD); end
        beat_q = '{32'h00BB_00AA, 32'h00DD_00CC}; dma_exp = 2;
        run_layer(1, 2, 1, 1, 1, 1);

        // mul stream held off while alu is ready
        mul_hold = 5;
        gen_layer(0, 1, 0, 1, 1, 1);
        run_layer(0, 1, 0, 1, 1, 1);

        gen_layer(0, 0, 0, 0, 1, 0);
        run_layer(0, 0, 0, 0, 1, 0);
        gen_layer(0, 0, 0, 0, 0, 1);
        run_layer(0, 0, 0, 0, 0, 1);
        gen_layer(0, 2, 1, 0, 0, 0);
        run_layer(0, 2, 1, 0, 0, 0);

        alu_hold = 7;
        gen_layer(0, 0, 0, 0, 1, 1);
        run_layer(0, 0, 0, 0, 1, 1);
`ifdef SDP_OP_FEED_PERF_EN
        chk("perf_literal", perf_stall_cnt, 7);
`endif

        // reset in the middle of a 4-beat layer
        gen_layer(0, 3, 0, 0, 1, 1);
        cfg_mode = 0; cfg_width = 3; cfg_height = 0; cfg_channel = 0;
        cfg_alu_en = 1; cfg_mul_en = 1; en_alu = 1; en_mul = 1; done_seen = 0;
        step(1);
        n = 0;
        while (!chn_alu_op_pvld && n < 50) begin step(0); n++; end
        chk("reach_send", chn_alu_op_pvld, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_outputs", {dma_rd_prdy, chn_alu_op_pvld, chn_mul_op_pvld, op_busy, op_done, chn_alu_op, chn_mul_op}, 0);
`ifdef SDP_OP_FEED_PERF_EN
        chk("midrst_perf", perf_stall_cnt, 0);
`endif
        op_en = 0; dma_rd_pvld = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        alu_q.delete(); mul_q.delete(); beat_q.delete();
        pa_v = 0; pm_v = 0; in_layer = 0; done_seen = 0;
        repeat (5) step(0);
        chk("no_done_after_rst", done_seen, 0);
        gen_layer(0, 3, 0, 0, 1, 1);
        run_layer(0, 3, 0, 0, 1, 1);

        for (int k = 0; k < 25; k++) begin
            bit m, ea, em;
            int w, h, c;
            m = 1'($urandom_range(1)); ea = 1'($urandom_range(1)); em = 1'($urandom_range(1));
            if (k % 6 != 5 && !(ea | em)) ea = 1;
            w = $urandom_range(3); h = $urandom_range(2); c = $urandom_range(2);
            alu_pct = $urandom_range(100, 30); mul_pct = $urandom_range(100, 30);
            pvld_pct = $urandom_range(100, 30);
            gen_layer(m, w, h, c, ea, em);
            run_layer(m, w, h, c, ea, em);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/sdp_bs_op_feed.md
Name: sdp_bs_op_feed

Overview:
Operand transmitter for the SDP BS integer pipeline. Accepts operand beats from the BS DMA read-return path and produces the per-lane ALU and MUL operand streams (chn_alu_op / chn_mul_op, valid/ready) that the x1 ALU/MUL stages consume. It supports per-element operands (one beat per output beat) and per-channel operands (one beat repeated across a W×H surface). Each output stream has its own independent handshake.

Parameters:
THROUGHPUT, 1, lanes per beat (NVDLA_SDP_BS_THROUGHPUT)
OP_DW, 16, operand width per lane

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rst  in  1  asynchronous reset, active-high
op_en  in  1  start pulse; cfg sampled this cycle
cfg_mode  in  1  0 = per-element, 1 = per-channel
cfg_width  in  13  surface width in beats, minus one
cfg_height  in  13  surface height, minus one
cfg_channel  in  13  channel count, minus one
cfg_alu_en  in  1  drive ALU operand stream
cfg_mul_en  in  1  drive MUL operand stream
dma_rd_pvld  in  1  operand beat valid
dma_rd_prdy  out  1  operand beat ready
dma_rd_pd  in  2*OP_DW*THROUGHPUT  lane i: ALU op at [32i+15:32i], MUL op at [32i+31:32i+16]
chn_alu_op_pvld  out  1  ALU operand valid
chn_alu_op_prdy  in  1  ALU operand ready
chn_alu_op  out  OP_DW*THROUGHPUT  ALU operands, lane i at [16i+15:16i]
chn_mul_op_pvld  out  1  MUL operand valid
chn_mul_op_prdy  in  1  MUL operand ready
chn_mul_op  out  OP_DW*THROUGHPUT  MUL operands
op_busy  out  1  layer in progress
op_done  out  1  one-cycle pulse after the last output beat

Behaviour:
- Reset: state IDLE; all valids, dma_rd_prdy, op_busy, op_done = 0; operand registers = 0; counters = 0.
- States: IDLE, LOAD, SEND.
- IDLE: op_en=1 latches cfg and clears the w/h/c counters.
  - If cfg_alu_en | cfg_mul_en: go to LOAD.
  - Otherwise: op_done pulses the next cycle and state stays IDLE. No DMA beat is consumed.
  - op_en while busy is ignored.
- op_busy = (state != IDLE).
- LOAD: dma_rd_prdy = 1.
  - On dma_rd_pvld: register the beat, set sent_alu = !cfg_alu_en and sent_mul = !cfg_mul_en, go to SEND.
  - A beat is registered before it is driven, so the first output valid comes 1 cycle after the DMA handshake.
- SEND:
  - chn_alu_op_pvld = !sent_alu; chn_mul_op_pvld = !sent_mul.
  - Each handshake sets its own sent flag. The two streams may complete in either order or in the same cycle.
  - An output beat completes when both flags are set, counting the completing handshake in that cycle. Completion advances the counters: w, then h at w wrap, then c at h wrap.
- Per-element mode: after completion go to LOAD (one DMA beat per output beat).
- Per-channel mode: after completion re-arm the flags and stay in SEND with the same operand. Go to LOAD only when the (w,h) pair wraps (new channel).
- Last beat: completion at w=cfg_width, h=cfg_height, c=cfg_channel → IDLE, op_done=1 next cycle.
- DMA beat totals:
  - Per-element: (W+1)(H+1)(C+1).
  - Per-channel: C+1.
- Operand data stays stable while its valid is high. Valid never drops without a handshake.
- Disabled stream: valid stays 0 and its data outputs hold 0.
- dma_rd_prdy = 0 in IDLE and SEND (no skid buffer). DMA beats arriving in those states are held off.
- Counters are 13-bit, compare-to-cfg. The all-zero cfg (1×1×1) is legal and produces one beat.
- Reset mid-layer: immediate return to the reset state. No op_done. Partial progress is discarded.

Optional Feature:
SDP_OP_FEED_PERF_EN
- Defined:
  - Adds output port perf_stall_cnt (32-bit).
  - Increments on every cycle in SEND where some enabled stream has valid=1 and ready=0.
  - Saturates at 0xFFFFFFFF, clears on accepted op_en, resets to 0.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
- Per-element, W=1,H=0,C=0 (cfg 1,0,0), both enabled, readys tied 1, DMA beats 0x0002_0001 then 0x0004_0003 → alu emits 0x0001, 0x0003; mul emits 0x0002, 0x0004; 2 DMA handshakes; op_done 1 cycle after the 2nd output handshake.
- Per-channel, cfg W=2,H=1,C=1, DMA beats 0x00BB_00AA, 0x00DD_00CC → 6× alu 0x00AA then 6× 0x00CC; mul likewise 0x00BB/0x00DD; exactly 2 DMA handshakes.
- Skewed ready: mul_prdy=0 for 5 cycles while alu_prdy=1 → alu handshakes once, alu valid drops, mul valid and data held stable; no new DMA beat accepted until mul handshakes.
- cfg_alu_en=1, cfg_mul_en=0, 1×1×1 → chn_mul_op_pvld never asserts, one alu beat, op_done pulses; with both disabled, op_done pulses 1 cycle after op_en and dma_rd_prdy never asserts.
- Reset asserted in SEND of a 4-beat layer → all outputs 0 within reset, no op_done; new op_en after reset runs the full layer correctly.
- Perf build: alu_prdy=0 for 7 SEND cycles → perf_stall_cnt=7; next op_en → 0.
